// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared types and encodings for the accumulator-machine control unit.
//   opcode_t   - instruction opcodes held in the IR opcode field
//   state_t    - multicycle control states
//   alu_op_t   - ALU operation select
//   ACC_SEL_*, PC_SEL_*, ADDR_SEL_*, ALU_B_* - datapath mux encodings
package ctrl_pkg;

  typedef enum logic [4:0] {
    OP_HLT  = 5'd0,
    OP_LD   = 5'd1,
    OP_STO  = 5'd2,
    OP_LDI  = 5'd3,
    OP_ADD  = 5'd4,
    OP_ADDI = 5'd5,
    OP_SUB  = 5'd6,
    OP_SUBI = 5'd7,
    OP_JMP  = 5'd8,
    OP_BEQ  = 5'd9,
    OP_BLT  = 5'd10
  } opcode_t;

  // Highest defined opcode; anything above it is illegal.
  localparam logic [31:0] OP_LAST = 32'd10;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    HALT   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'd0,
    ALU_SUB    = 2'd1,
    ALU_PASS_B = 2'd2
  } alu_op_t;

  localparam logic [1:0] ACC_SEL_ALU = 2'd0;
  localparam logic [1:0] ACC_SEL_MEM = 2'd1;
  localparam logic [1:0] ACC_SEL_IMM = 2'd2;

  localparam logic PC_SEL_INC  = 1'b0;
  localparam logic PC_SEL_IR   = 1'b1;
  localparam logic ADDR_SEL_PC = 1'b0;
  localparam logic ADDR_SEL_IR = 1'b1;
  localparam logic ALU_B_MEM   = 1'b0;
  localparam logic ALU_B_IMM   = 1'b1;

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog: counts consecutive cycles a memory request waits without ack.
//   clock   - system clock
//   reset_n - synchronous active-low reset
//   req     - memory request currently asserted
//   ack     - memory completion this cycle
//   clear   - controller is changing state; restart the count
//   expired - this is the MEM_TIMEOUT-th unacknowledged request cycle
// An ack in the final allowed cycle suppresses expired, so ack always wins.
module mem_watchdog #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  input  logic ack,
  input  logic clear,
  output logic expired
);

  localparam int TIMEOUT_WIDTH = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TIMEOUT_WIDTH-1:0] LAST_WAIT = TIMEOUT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [TIMEOUT_WIDTH-1:0] CNT_MAX   = TIMEOUT_WIDTH'(MEM_TIMEOUT);

  logic [TIMEOUT_WIDTH-1:0] count_r;

  assign expired = req & ~ack & (count_r == LAST_WAIT);

  // Wait-cycle counter; saturates so it can never wrap back below the limit.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_r <= '0;
    end else if (clear || ack || !req) begin
      count_r <= '0;
    end else if (count_r != CNT_MAX) begin
      count_r <= count_r + TIMEOUT_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: multicycle FETCH/DECODE/EXEC/MEM control FSM for the accumulator datapath.
// Inputs : clock, ctrl_reset_n (sync, active-low), ctrl_opcode (IR opcode field),
//          ctrl_mem_ack, ctrl_zero, ctrl_neg, ctrl_step (only with CTRL_STEP_EN).
// Outputs: ctrl_reg_reset, ctrl_pc_wr/ir_wr/acc_wr strobes, ctrl_pc_sel, ctrl_acc_sel,
//          ctrl_alu_op, ctrl_alu_b_sel, ctrl_addr_sel, ctrl_mem_req, ctrl_mem_we,
//          sticky ctrl_halted/ctrl_illegal/ctrl_fault.
// Build option: define CTRL_STEP_EN to add single-step control via ctrl_step.
// Strobes are combinational because register writes must land in the ack cycle.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 5,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic                    clock,
  input  logic                    ctrl_reset_n,
  input  logic [OPCODE_WIDTH-1:0] ctrl_opcode,
  input  logic                    ctrl_mem_ack,
  input  logic                    ctrl_zero,
  input  logic                    ctrl_neg,
`ifdef CTRL_STEP_EN
  input  logic                    ctrl_step,
`endif
  output logic                    ctrl_reg_reset,
  output logic                    ctrl_pc_wr,
  output logic                    ctrl_ir_wr,
  output logic                    ctrl_acc_wr,
  output logic                    ctrl_pc_sel,
  output logic [1:0]              ctrl_acc_sel,
  output logic [1:0]              ctrl_alu_op,
  output logic                    ctrl_alu_b_sel,
  output logic                    ctrl_addr_sel,
  output logic                    ctrl_mem_req,
  output logic                    ctrl_mem_we,
  output logic                    ctrl_halted,
  output logic                    ctrl_illegal,
  output logic                    ctrl_fault
);

  state_t      state_r, next_state_s;
  logic        halted_r, illegal_r, fault_r;
  logic        set_illegal_s, set_fault_s;
  logic        fetch_go_s, mem_req_s, wd_expired_s, wd_clear_s;
  logic [31:0] op_ext_s;
  logic        op_in_range_s;
  opcode_t     op_s;

  // Widen first so the range check works for any opcode field width.
  assign op_ext_s      = 32'(ctrl_opcode);
  assign op_in_range_s = (op_ext_s <= OP_LAST);
  assign op_s          = opcode_t'(op_ext_s[4:0]);

`ifdef CTRL_STEP_EN
  logic step_pending_r;

  // One-deep step request; consumption on entry to DECODE beats a coincident pulse.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      step_pending_r <= 1'b0;
    end else if (next_state_s == DECODE) begin
      step_pending_r <= 1'b0;
    end else if (ctrl_step) begin
      step_pending_r <= 1'b1;
    end else begin
      step_pending_r <= step_pending_r;
    end
  end

  assign fetch_go_s = step_pending_r;
`else
  assign fetch_go_s = 1'b1;
`endif

  // Kept outside the FSM block so the watchdog sees req without a combinational loop.
  assign mem_req_s = ctrl_reset_n &
                     (((state_r == FETCH) & fetch_go_s) | (state_r == MEM));
  assign wd_clear_s = (next_state_s != state_r);

  mem_watchdog #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_watchdog (
    .clock  (clock),
    .reset_n(ctrl_reset_n),
    .req    (mem_req_s),
    .ack    (ctrl_mem_ack),
    .clear  (wd_clear_s),
    .expired(wd_expired_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_r <= FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    next_state_s   = state_r;
    set_illegal_s  = 1'b0;
    set_fault_s    = 1'b0;
    ctrl_pc_wr     = 1'b0;
    ctrl_ir_wr     = 1'b0;
    ctrl_acc_wr    = 1'b0;
    ctrl_pc_sel    = PC_SEL_INC;
    ctrl_acc_sel   = ACC_SEL_ALU;
    ctrl_alu_op    = ALU_ADD;
    ctrl_alu_b_sel = ALU_B_MEM;
    ctrl_addr_sel  = ADDR_SEL_PC;
    ctrl_mem_we    = 1'b0;
    if (!ctrl_reset_n) begin
      next_state_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          if (mem_req_s && ctrl_mem_ack) begin
            ctrl_ir_wr   = 1'b1;
            ctrl_pc_wr   = 1'b1;
            next_state_s = DECODE;
          end else if (wd_expired_s) begin
            set_fault_s  = 1'b1;
            next_state_s = HALT;
          end else begin
            next_state_s = FETCH;
          end
        end
        DECODE: begin
          if (!op_in_range_s) begin
            set_illegal_s = 1'b1;
            next_state_s  = HALT;
          end else begin
            case (op_s)
              OP_LD, OP_STO, OP_ADD, OP_SUB: next_state_s = MEM;
              OP_HLT:                        next_state_s = HALT;
              default:                       next_state_s = EXEC;
            endcase
          end
        end
        EXEC: begin
          next_state_s = FETCH;
          case (op_s)
            OP_LDI: begin
              ctrl_acc_wr  = 1'b1;
              ctrl_acc_sel = ACC_SEL_IMM;
            end
            OP_ADDI: begin
              ctrl_acc_wr    = 1'b1;
              ctrl_alu_b_sel = ALU_B_IMM;
            end
            OP_SUBI: begin
              ctrl_acc_wr    = 1'b1;
              ctrl_alu_b_sel = ALU_B_IMM;
              ctrl_alu_op    = ALU_SUB;
            end
            OP_JMP: begin
              ctrl_pc_wr  = 1'b1;
              ctrl_pc_sel = PC_SEL_IR;
            end
            OP_BEQ: begin
              ctrl_pc_wr  = ctrl_zero;
              ctrl_pc_sel = PC_SEL_IR;
            end
            OP_BLT: begin
              ctrl_pc_wr  = ctrl_neg;
              ctrl_pc_sel = PC_SEL_IR;
            end
            default: begin
              ctrl_pc_wr = 1'b0;
            end
          endcase
        end
        MEM: begin
          ctrl_addr_sel = ADDR_SEL_IR;
          ctrl_mem_we   = (op_s == OP_STO);
          if (ctrl_mem_ack) begin
            next_state_s = FETCH;
            case (op_s)
              OP_LD: begin
                ctrl_acc_wr  = 1'b1;
                ctrl_acc_sel = ACC_SEL_MEM;
              end
              OP_ADD: begin
                ctrl_acc_wr = 1'b1;
              end
              OP_SUB: begin
                ctrl_acc_wr = 1'b1;
                ctrl_alu_op = ALU_SUB;
              end
              default: begin
                ctrl_acc_wr = 1'b0;
              end
            endcase
          end else if (wd_expired_s) begin
            set_fault_s  = 1'b1;
            next_state_s = HALT;
          end else begin
            next_state_s = MEM;
          end
        end
        HALT: begin
          next_state_s = HALT;
        end
        default: begin
          next_state_s = FETCH;
        end
      endcase
    end
  end

  // Sticky status flags, cleared only by reset.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      halted_r  <= 1'b0;
      illegal_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      halted_r  <= halted_r | (next_state_s == HALT);
      illegal_r <= illegal_r | set_illegal_s;
      fault_r   <= fault_r | set_fault_s;
    end
  end

  assign ctrl_reg_reset = ~ctrl_reset_n;
  assign ctrl_mem_req   = mem_req_s;
  assign ctrl_halted    = halted_r;
  assign ctrl_illegal   = illegal_r;
  assign ctrl_fault     = fault_r;

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: randomized instruction streams checked against an instruction-level
// phase model (fetch waits, decode, execute/memory phase) built from the opcode rules.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_ctrl_unit;

  logic       clock = 1'b0;
  logic       ctrl_reset_n;
  logic [4:0] ctrl_opcode;
  logic       ctrl_mem_ack, ctrl_zero, ctrl_neg;
`ifdef CTRL_STEP_EN
  logic       ctrl_step;
  logic       step_hook;
`endif
  logic       ctrl_reg_reset, ctrl_pc_wr, ctrl_ir_wr, ctrl_acc_wr, ctrl_pc_sel;
  logic [1:0] ctrl_acc_sel, ctrl_alu_op;
  logic       ctrl_alu_b_sel, ctrl_addr_sel, ctrl_mem_req, ctrl_mem_we;
  logic       ctrl_halted, ctrl_illegal, ctrl_fault;

  int   total = 0;
  int   bad   = 0;
  logic m_halted, m_illegal, m_fault;

  always #5 clock = ~clock;

  ctrl_unit dut (
    .clock         (clock),
    .ctrl_reset_n  (ctrl_reset_n),
    .ctrl_opcode   (ctrl_opcode),
    .ctrl_mem_ack  (ctrl_mem_ack),
    .ctrl_zero     (ctrl_zero),
    .ctrl_neg      (ctrl_neg),
`ifdef CTRL_STEP_EN
    .ctrl_step     (ctrl_step),
`endif
    .ctrl_reg_reset(ctrl_reg_reset),
    .ctrl_pc_wr    (ctrl_pc_wr),
    .ctrl_ir_wr    (ctrl_ir_wr),
    .ctrl_acc_wr   (ctrl_acc_wr),
    .ctrl_pc_sel   (ctrl_pc_sel),
    .ctrl_acc_sel  (ctrl_acc_sel),
    .ctrl_alu_op   (ctrl_alu_op),
    .ctrl_alu_b_sel(ctrl_alu_b_sel),
    .ctrl_addr_sel (ctrl_addr_sel),
    .ctrl_mem_req  (ctrl_mem_req),
    .ctrl_mem_we   (ctrl_mem_we),
    .ctrl_halted   (ctrl_halted),
    .ctrl_illegal  (ctrl_illegal),
    .ctrl_fault    (ctrl_fault)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] obs();
    return {ctrl_reg_reset, ctrl_pc_wr, ctrl_ir_wr, ctrl_acc_wr, ctrl_pc_sel,
            ctrl_acc_sel, ctrl_alu_op, ctrl_alu_b_sel, ctrl_addr_sel,
            ctrl_mem_req, ctrl_mem_we, ctrl_halted, ctrl_illegal, ctrl_fault};
  endfunction

  // Expected output vector; reg_reset low, flags from the model.
  function automatic logic [15:0] ev(input logic pc_wr, ir_wr, acc_wr, pc_sel,
                                     input logic [1:0] acc_sel, alu_op,
                                     input logic b_sel, addr_sel, req, we);
    return {1'b0, pc_wr, ir_wr, acc_wr, pc_sel, acc_sel, alu_op, b_sel, addr_sel,
            req, we, m_halted, m_illegal, m_fault};
  endfunction

  function automatic logic [15:0] idle();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] fetch_wait();
    return ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Drive ack for one cycle, check outputs mid-cycle, advance to next falling edge.
  task automatic cyc(input logic ack, input logic [15:0] exp, input string tag);
    ctrl_mem_ack = ack;
    #1;
    check_eq(tag, obs(), exp);
    @(negedge clock);
  endtask

  // Reset for n cycles with ack high; flags are visible until the first edge.
  task automatic do_reset(input int n);
    ctrl_reset_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, idle() | 16'h8000, "reset");
      m_halted  = 1'b0;
      m_illegal = 1'b0;
      m_fault   = 1'b0;
    end
    ctrl_reset_n = 1'b1;
`ifdef CTRL_STEP_EN
    cyc(1'b0, idle(), "step_idle");
`endif
  endtask

  // One full instruction: fw fetch waits, decode, then execute or memory phase.
  task automatic run_instr(input int op, input int fw, input int mw, input logic z, input logic n);
    logic is_mem;
    ctrl_opcode = 5'(op);
    ctrl_zero   = z;
    ctrl_neg    = n;
    is_mem      = (op == 1) || (op == 2) || (op == 4) || (op == 6);
    for (int i = 0; i < fw; i++) cyc(1'b0, fetch_wait(), "fetch_wait");
    cyc(1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "fetch_ack");
`ifdef CTRL_STEP_EN
    if (step_hook) ctrl_step = 1'b1;
`endif
    cyc(rbit(), idle(), "decode");
`ifdef CTRL_STEP_EN
    if (step_hook) ctrl_step = 1'b0;
`endif
    if (is_mem) begin
      for (int i = 0; i < mw; i++)
        cyc(1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, op == 2), "mem_wait");
      cyc(1'b1, ev(1'b0, 1'b0, op != 2, 1'b0, (op == 1) ? 2'd1 : 2'd0, (op == 6) ? 2'd1 : 2'd0,
                   1'b0, 1'b1, 1'b1, op == 2), "mem_ack");
    end else begin
      case (op)
        3:       cyc(rbit(), ev(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_ldi");
        5:       cyc(rbit(), ev(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0), "exec_addi");
        7:       cyc(rbit(), ev(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0), "exec_subi");
        8:       cyc(rbit(), ev(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_jmp");
        9:       cyc(rbit(), ev(z,    1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_beq");
        default: cyc(rbit(), ev(n,    1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0), "exec_blt");
      endcase
    end
  endtask

  // HLT or illegal opcode: halt for 20 cycles, then reset clears everything.
  task automatic run_halt(input int op);
    ctrl_opcode = 5'(op);
    cyc(1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "halt_fetch");
    cyc(1'b0, idle(), "halt_decode");
    m_halted = 1'b1;
    if (op != 0) m_illegal = 1'b1;
    for (int i = 0; i < 20; i++) cyc(rbit(), idle(), "halted");
    do_reset(1);
  endtask

  // Ack withheld for 15 request cycles in FETCH (in_mem=0) or MEM (in_mem=1).
  task automatic run_timeout(input logic in_mem);
    ctrl_opcode = 5'd1;
    if (in_mem) begin
      cyc(1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "to_fetch_ack");
      cyc(1'b0, idle(), "to_decode");
    end
    for (int i = 0; i < 15; i++)
      cyc(1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, in_mem, 1'b1, 1'b0), "to_wait");
    m_halted = 1'b1;
    m_fault  = 1'b1;
    for (int i = 0; i < 3; i++) cyc(rbit(), idle(), "to_halt");
    do_reset(1);
  endtask

  initial begin
    #1000000;
    $display("FAIL sim_time_limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int op, fw, mw;
    ctrl_reset_n = 1'b0;
    ctrl_mem_ack = 1'b0;
    ctrl_opcode  = 5'd0;
    ctrl_zero    = 1'b0;
    ctrl_neg     = 1'b0;
`ifdef CTRL_STEP_EN
    ctrl_step    = 1'b1;
    step_hook    = 1'b0;
`endif
    m_halted  = 1'b0;
    m_illegal = 1'b0;
    m_fault   = 1'b0;
    @(negedge clock);
    @(negedge clock);
    do_reset(2);

    // LDI with zero-wait memory: 3 cycles each, back to back.
    for (int i = 0; i < 3; i++) run_instr(3, 0, 0, 1'b0, 1'b0);
    // ADD with a 4-cycle ack delay in MEM.
    run_instr(4, 0, 4, 1'b0, 1'b0);
    // BEQ not taken, then taken; BLT both ways.
    run_instr(9, 0, 0, 1'b0, 1'b0);
    run_instr(9, 0, 0, 1'b1, 1'b0);
    run_instr(10, 1, 0, 1'b0, 1'b1);
    run_instr(10, 1, 0, 1'b1, 1'b0);
    // Ack on the 15th request cycle: ack wins in both FETCH and MEM.
    run_instr(1, 14, 14, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(1, 10);
      fw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 3);
      mw = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 3);
      run_instr(op, fw, mw, rbit(), rbit());
    end

    run_halt(15);
    run_halt(0);
    run_halt($urandom_range(11, 31));
    run_instr(5, 0, 0, 1'b0, 1'b0);
    run_timeout(1'b0);
    run_timeout(1'b1);

    // Reset during a MEM wait with ack arriving in the same cycle.
    ctrl_opcode = 5'd4;
    cyc(1'b1, ev(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0), "abort_fetch");
    cyc(1'b0, idle(), "abort_decode");
    cyc(1'b0, ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0), "abort_wait");
    do_reset(1);
    cyc(1'b0, fetch_wait(), "post_reset_fetch");
    run_instr(6, 1, 2, 1'b0, 1'b0);

`ifdef CTRL_STEP_EN
    ctrl_step = 1'b0;
    run_instr(3, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, idle(), "step_none");
    ctrl_step = 1'b1;
    cyc(1'b0, idle(), "step_pulse");
    ctrl_step = 1'b0;
    step_hook = 1'b1;
    run_instr(3, 0, 0, 1'b0, 1'b0);
    step_hook = 1'b0;
    run_instr(5, 0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, idle(), "step_done");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_unit.md
Name: ctrl_unit

Overview:
Multicycle control FSM for the 11-bit accumulator datapath. Sequences the PC, IR and ACC registers and the external memory port through fetch, decode, execute and memory phases. Drives each register's write and reset strobes, the datapath mux selects and the ALU operation. Sits between the register/ALU datapath and the memory interface.

Parameters:
OPCODE_WIDTH, 5, width of the IR opcode field.
MEM_TIMEOUT, 15, maximum cycles to wait for ctrl_mem_ack before faulting (1..255).
TIMEOUT_WIDTH, $clog2(MEM_TIMEOUT+1), watchdog counter width (derived, not overridden).

Ports:
clock  in  1  system clock; all state updates on posedge.
ctrl_reset_n  in  1  synchronous, active-low reset.
ctrl_opcode  in  OPCODE_WIDTH  opcode field of the IR output.
ctrl_mem_ack  in  1  memory completion; read data valid in the same cycle.
ctrl_zero  in  1  ACC == 0 status.
ctrl_neg  in  1  ACC negative status (MSB).
ctrl_reg_reset  out  1  active-high reset to datapath registers.
ctrl_pc_wr, ctrl_ir_wr, ctrl_acc_wr  out  1 each  register write strobes.
ctrl_pc_sel  out  1  0 = PC+1, 1 = IR operand.
ctrl_acc_sel  out  2  0 = ALU, 1 = memory data, 2 = immediate.
ctrl_alu_op  out  2  0 = ADD, 1 = SUB, 2 = PASS_B.
ctrl_alu_b_sel  out  1  0 = memory data, 1 = immediate.
ctrl_addr_sel  out  1  0 = PC, 1 = IR operand.
ctrl_mem_req, ctrl_mem_we  out  1 each  memory request and write enable.
ctrl_halted, ctrl_illegal, ctrl_fault  out  1 each  sticky status flags.

Behaviour:
- One clock (clock); reset is synchronous and active-low (ctrl_reset_n).
- ctrl_reg_reset = ~ctrl_reset_n, combinational.
- While ctrl_reset_n is low: all strobes and ctrl_mem_req are forced to 0 combinationally.
- Next edge after reset: state = FETCH, watchdog = 0, halted/illegal/fault = 0. Selects reset to 0.
- Reset asserted mid-operation aborts immediately, including an outstanding memory request. No partial writes.
- Opcodes: HLT 0, LD 1, STO 2, LDI 3, ADD 4, ADDI 5, SUB 6, SUBI 7, JMP 8, BEQ 9, BLT 10. All others are illegal.
- FETCH: mem_req = 1, addr_sel = 0. On ack, same cycle: ir_wr = 1, pc_wr = 1, pc_sel = 0; then go to DECODE.
- DECODE (1 cycle, no strobes):
  - LD/STO/ADD/SUB go to MEM.
  - LDI/ADDI/SUBI/JMP/BEQ/BLT go to EXEC.
  - HLT goes to HALT.
  - Illegal opcode goes to HALT and sets illegal.
- EXEC (1 cycle), then FETCH:
  - LDI: acc_wr = 1, acc_sel = 2.
  - ADDI/SUBI: acc_wr = 1, acc_sel = 0, alu_b_sel = 1, alu_op = ADD/SUB.
  - JMP: pc_wr = 1, pc_sel = 1.
  - BEQ: pc_wr = ctrl_zero. BLT: pc_wr = ctrl_neg. Both with pc_sel = 1.
- MEM: mem_req = 1, addr_sel = 1; STO also drives mem_we = 1. On ack, same cycle:
  - LD: acc_wr = 1, acc_sel = 1.
  - ADD/SUB: acc_wr = 1, acc_sel = 0, alu_b_sel = 0.
  - STO: no register write.
  - Then go to FETCH.
- Watchdog:
  - Counts cycles with mem_req = 1 and no ack; clears on ack or state change.
  - Ack in the cycle the count reaches MEM_TIMEOUT: ack wins, no fault.
  - Count reaching MEM_TIMEOUT without ack: go to HALT, set fault, drop mem_req next cycle.
- HALT: all strobes 0, halted = 1. Exit only by reset.
- Latency with zero-wait memory: every instruction takes 3 cycles. Each ack wait cycle adds 1.
- Flags are sticky until reset.

Optional Feature:
CTRL_STEP_EN.
- Defined: adds input ctrl_step (1 bit).
  - A step_pending flag sets on a ctrl_step pulse and clears on entry to DECODE.
  - FETCH asserts mem_req only while step_pending = 1, so each pulse executes exactly one instruction.
  - A pulse arriving while busy is held; further pulses before it is consumed are ignored.
  - step_pending resets to 0.
- Undefined: port and flag are absent; execution is continuous.

Decomposition:
- Package ctrl_pkg holds:
  - opcode_t enum (values above) and state_t enum (FETCH, DECODE, EXEC, MEM, HALT).
  - alu_op_t enum and acc_sel encodings (ACC_SEL_ALU/MEM/IMM).
  - PC_SEL_*/ADDR_SEL_* constants.
- One sub-module, mem_watchdog: counter with req/ack/clear inputs and an expired output, parameterised by MEM_TIMEOUT.

Test Plan:
- Reset with ack tied high, opcode LDI(3) -> cycle 1 ir_wr+pc_wr, cycle 2 no strobes, cycle 3 acc_wr with acc_sel = 2; repeats every 3 cycles.
- ADD(4) with ack delayed 4 cycles in MEM -> mem_req = 1 and addr_sel = 1 for 5 cycles; acc_wr with alu_op = 0, alu_b_sel = 0 only in the ack cycle.
- BEQ(9) with zero = 0, then zero = 1 -> no pc_wr in EXEC, then pc_wr = 1 with pc_sel = 1.
- Opcode 15 -> HALT; illegal = 1, halted = 1, all strobes 0 for 20 cycles; ctrl_reset_n low one cycle clears everything.
- Ack withheld in FETCH -> fault = 1 after exactly 15 request cycles. Repeat with ack on cycle 15 -> no fault, ir_wr = 1.
- ctrl_reset_n low during a MEM wait with ack arriving that same cycle -> no acc_wr, reg_reset = 1, state FETCH next cycle.
- CTRL_STEP_EN: one ctrl_step pulse -> exactly one instruction completes; a second pulse mid-instruction -> exactly one more.
